// File: rtl/filter_sel_sequencer.sv
// filter_sel_sequencer: click-free mode switching in front of a selectable FIR smoother.
// A mode change fades the output gain to zero, switches filt_sel, lets the filter's
// delay line flush, then fades the gain back up. The filter output is scaled by the
// current ramp gain on every sample strobe.
// Optional build macro SEL_RETARGET_EN: requests are always accepted, and a request
// that arrives mid-sequence retargets the switch in progress.
module filter_sel_sequencer #(
  parameter int         BIT_WIDTH     = 24,
  parameter int         GAIN_BITS     = 6,
  parameter int         FLUSH_SAMPLES = 16,
  parameter logic [2:0] RESET_SEL     = 3'b000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sample_en,
  input  logic [2:0]                  sel_req,
  input  logic                        sel_req_valid,
  output logic                        sel_req_ready,
  output logic [2:0]                  filt_sel,
  input  logic signed [BIT_WIDTH-1:0] filt_q,
  output logic signed [BIT_WIDTH-1:0] audio_out,
  output logic                        audio_out_valid,
  output logic                        busy
);

  localparam int GW  = GAIN_BITS + 1;                    // gain spans 0..2^GAIN_BITS
  localparam int FCW = $clog2(FLUSH_SAMPLES + 1);
  localparam int PW  = BIT_WIDTH + GAIN_BITS + 2;        // product width incl. sign headroom

  localparam logic [GW-1:0]  GMAX       = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [GW-1:0]  GMAX_M1    = {1'b0, {GAIN_BITS{1'b1}}};
  localparam logic [GW-1:0]  GAIN_ONE   = GW'(1);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_SAMPLES);
  localparam logic [FCW-1:0] FLUSH_ONE  = FCW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FLUSH    = 2'd2,
    FADE_IN  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          gain_q, gain_d;
  logic [FCW-1:0]         flush_cnt_q, flush_cnt_d;
  logic [2:0]             pending_q, pending_d;
  logic [2:0]             filt_sel_q, filt_sel_d;
  logic signed [BIT_WIDTH-1:0] audio_q;
  logic                   audio_valid_q;
  logic                   req_fire;

  // Gain is zero-extended so it always multiplies as a positive value; the slice
  // [GAIN_BITS +: BIT_WIDTH] is the arithmetic (floor) shift right by GAIN_BITS.
  logic signed [PW-1:0]        product_full;
  logic signed [BIT_WIDTH-1:0] scaled;
  logic                        unused_product_bits;

  assign product_full = PW'(filt_q) * PW'($signed({1'b0, gain_q}));
  assign scaled       = product_full[GAIN_BITS +: BIT_WIDTH];
  assign unused_product_bits = ^{product_full[PW-1:GAIN_BITS+BIT_WIDTH],
                                 product_full[GAIN_BITS-1:0]};

`ifdef SEL_RETARGET_EN
  assign sel_req_ready = 1'b1;
`else
  assign sel_req_ready = (state_q == IDLE);
`endif
  assign req_fire        = sel_req_valid && sel_req_ready;
  assign busy            = (state_q != IDLE);
  assign filt_sel        = filt_sel_q;
  assign audio_out       = audio_q;
  assign audio_out_valid = audio_valid_q;

  // Sequencer state, gain ramp, flush counter and mode registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gain_q      <= GMAX;
      flush_cnt_q <= '0;
      pending_q   <= '0;
      filt_sel_q  <= RESET_SEL;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      flush_cnt_q <= flush_cnt_d;
      pending_q   <= pending_d;
      filt_sel_q  <= filt_sel_d;
    end
  end

  // Next-state logic: ramps advance only on sample strobes, requests act on acceptance.
  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    flush_cnt_d = flush_cnt_q;
    pending_d   = pending_q;
    filt_sel_d  = filt_sel_q;
    case (state_q)
      IDLE: begin
        if (req_fire && (sel_req != filt_sel_q)) begin
          pending_d = sel_req;
          state_d   = FADE_OUT;
        end
      end
      FADE_OUT: begin
`ifdef SEL_RETARGET_EN
        if (req_fire) pending_d = sel_req;
`endif
        if (sample_en) begin
          // gain_q can be 0 only after a retarget from the start of FADE_IN
          if (gain_q <= GAIN_ONE) begin
            gain_d      = '0;
            filt_sel_d  = pending_d;
            flush_cnt_d = FLUSH_LOAD;
            state_d     = FLUSH;
          end else begin
            gain_d = gain_q - GAIN_ONE;
          end
        end
      end
      FLUSH: begin
        if (sample_en) begin
          if (flush_cnt_q <= FLUSH_ONE) begin
            flush_cnt_d = '0;
            state_d     = FADE_IN;
          end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_ONE;
          end
        end
`ifdef SEL_RETARGET_EN
        if (req_fire) begin
          filt_sel_d  = sel_req;
          pending_d   = sel_req;
          flush_cnt_d = FLUSH_LOAD;
          state_d     = FLUSH;
        end
`endif
      end
      FADE_IN: begin
        if (sample_en) begin
          if (gain_q >= GMAX_M1) begin
            gain_d  = GMAX;
            state_d = IDLE;
          end else begin
            gain_d = gain_q + GAIN_ONE;
          end
        end
`ifdef SEL_RETARGET_EN
        if (req_fire && (sel_req != filt_sel_q)) begin
          pending_d = sel_req;
          state_d   = FADE_OUT;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Output datapath: scale with the pre-update gain, valid one clk after the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      audio_q       <= '0;
      audio_valid_q <= 1'b0;
    end else begin
      audio_valid_q <= sample_en;
      if (sample_en) audio_q <= scaled;
    end
  end

endmodule

// File: tb/tb_filter_sel_sequencer.sv
// Testbench for filter_sel_sequencer: directed scenarios plus randomized traffic.
// Expected outputs come from a strobe-count reference model and are checked by a
// scoreboard monitor whenever audio_out_valid is presented.
module tb_filter_sel_sequencer;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sample_en = 1'b0;
  logic [2:0]        sel_req = 3'd0;
  logic              sel_req_valid = 1'b0;
  logic              sel_req_ready;
  logic [2:0]        filt_sel;
  logic signed [23:0] filt_q = '0;
  logic signed [23:0] audio_out;
  logic              audio_out_valid;
  logic              busy;

  filter_sel_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample_en      (sample_en),
    .sel_req        (sel_req),
    .sel_req_valid  (sel_req_valid),
    .sel_req_ready  (sel_req_ready),
    .filt_sel       (filt_sel),
    .filt_q         (filt_q),
    .audio_out      (audio_out),
    .audio_out_valid(audio_out_valid),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [23:0] audio;
    logic [2:0]         sel;
    logic               bsy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: a switch is a fixed 144-strobe script counted from acceptance.
  bit         m_busy = 0;
  int         m_cnt  = 0;
  logic [2:0] m_sel  = 3'd0;
  logic [2:0] m_pend = 3'd0;
  bit         v_hold = 0;
  logic [2:0] r_hold = 3'd0;

  // Gain applied on a strobe, given how many strobes of the switch have already passed.
  function automatic int gain_at(int k);
    if (k < 64) return 64 - k;
    else if (k < 80) return 0;
    else return k - 80;
  endfunction

  function automatic logic signed [23:0] scale(logic signed [23:0] f, int g);
    longint p;
    p = longint'(f) * longint'(g);
    p = p >>> 6;
    return p[23:0];
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus, driven just after a falling edge; ends at the next falling edge.
  task automatic cyc(input bit se, input bit v, input logic [2:0] r, input logic signed [23:0] f);
    bit   was_busy;
    exp_t e;
    sample_en     = se;
    sel_req_valid = v;
    sel_req       = r;
    filt_q        = f;
    was_busy = m_busy;
    e = '0;
    if (se) begin
      e.audio = m_busy ? scale(f, gain_at(m_cnt)) : scale(f, 64);
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 64)  m_sel  = m_pend;
        if (m_cnt == 144) m_busy = 0;
      end
    end
    if (v && !was_busy && (r != m_sel)) begin
      m_busy = 1;
      m_cnt  = 0;
      m_pend = r;
    end
    if (v && !was_busy) v_hold = 0;
    if (se) begin
      e.sel = m_sel;
      e.bsy = m_busy;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Asynchronous reset applied between clock edges, checked before any edge arrives.
  task automatic mid_reset();
    sample_en     = 1'b0;
    sel_req_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_filt_sel", filt_sel, 0);
    chk("rst_audio_out", audio_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", sel_req_ready, 1);
    chk("rst_valid", audio_out_valid, 0);
    m_busy = 0;
    m_sel  = 3'd0;
    v_hold = 0;
    exp_q.delete();
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard monitor: every valid output must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && audio_out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected_valid: got valid with audio %0d, expected no output", audio_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_audio_out", audio_out, e.audio);
        chk("sb_filt_sel", filt_sel, e.sel);
        chk("sb_busy", busy, e.bsy);
        chk("sb_ready", sel_req_ready, !e.bsy);
      end
    end
  end

  initial begin
    logic signed [23:0] f;
    bit se;
    int p;

    // Power-up reset and its release
    @(negedge clk);
    chk("por_filt_sel", filt_sel, 0);
    chk("por_busy", busy, 0);
    chk("por_ready", sel_req_ready, 1);
    chk("por_audio_out", audio_out, 0);
    reset_n = 1'b1;
    cyc(0, 0, 3'd0, 24'sd0);

    // Passthrough at full gain, valid exactly one clk later and for one clk only
    cyc(1, 0, 3'd0, 24'sh100000);
    chk("pass_valid", audio_out_valid, 1);
    chk("pass_audio", audio_out, 24'sh100000);
    cyc(0, 0, 3'd0, 24'sh100000);
    chk("pass_valid_drop", audio_out_valid, 0);

    // Switch to mode 3 with a strobe every 4 clks
    cyc(0, 1, 3'd3, 24'sh400000);
    chk("sw_ready_low", sel_req_ready, 0);
    chk("sw_busy_high", busy, 1);
    for (int k = 1; k <= 146; k++) begin
      cyc(1, 0, 3'd0, 24'sh400000);
      if (k == 33)  chk("sw_half_gain", audio_out, 24'sh200000);
      if (k == 63)  chk("sw_sel_before", filt_sel, 0);
      if (k == 64)  chk("sw_sel_after", filt_sel, 3);
      if (k == 144) chk("sw_busy_end", busy, 0);
      if (k == 145) chk("sw_full_again", audio_out, 24'sh400000);
      repeat (3) cyc(0, 0, 3'd0, 24'sh400000);
    end

    // Same-mode request is accepted as a no-op
    cyc(0, 1, 3'd3, 24'sd0);
    chk("same_busy", busy, 0);
    chk("same_filt_sel", filt_sel, 3);
    cyc(1, 0, 3'd0, 24'sh0abcde);

    // Negative floor rounding (-3 at gain 32) then reset during FLUSH with pending 101
    cyc(1, 1, 3'd5, -24'sd3);
    for (int k = 1; k <= 70; k++) begin
      cyc(1, 0, 3'd0, -24'sd3);
      if (k == 33) chk("neg3_gain32", audio_out, -24'sd2);
    end
    chk("flush_audio_zero", audio_out, 0);
    chk("flush_sel_pending", filt_sel, 5);
    mid_reset();
    cyc(1, 0, 3'd0, 24'sh123456);
    chk("post_rst_unscaled", audio_out, 24'sh123456);

    // Negative floor rounding (-1 at gain 32) on a full switch to mode 6
    cyc(0, 1, 3'd6, 24'sd0);
    for (int k = 1; k <= 145; k++) begin
      cyc(1, 0, 3'd0, -24'sd1);
      if (k == 33) chk("neg1_gain32", audio_out, -24'sd1);
    end

    // Randomized traffic: varying strobe density, requesters hold valid until accepted
    for (int blk = 0; blk < 12; blk++) begin
      p = (blk % 3 == 0) ? 100 : (blk % 3 == 1) ? 50 : 20;
      for (int c = 0; c < 300; c++) begin
        se = ($urandom_range(99) < p);
        f  = 24'($urandom);
        if (!v_hold && ($urandom_range(29) == 0)) begin
          v_hold = 1;
          r_hold = 3'($urandom_range(7));
        end
        cyc(se, v_hold, r_hold, f);
      end
    end

    // Drain and confirm every expected output was produced
    repeat (3) cyc(0, 0, 3'd0, 24'sd0);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
